// File: rtl/sobel_window_loader.sv
// sobel_window_loader: fetches pixels and holds the 3x3 Sobel window.
// Optional read timeout enabled by SOBEL_WINLOAD_TIMEOUT_EN.
module sobel_window_loader #(
    parameter int ADDR_W  = 8,
    parameter int PIX_W   = 8,
    parameter int LEN_W   = 12,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic [LEN_W-1:0]   length,
    input  logic               start_load,
    input  logic [1:0]         direction,
    input  logic [ADDR_W-1:0]  center_addr,
    output logic               mem_read,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [PIX_W-1:0]   mem_rdata,
    input  logic               mem_rvalid,
    output logic [9*PIX_W-1:0] window,
    output logic               window_valid,
    output logic               busy,
    output logic               load_done,
    output logic               load_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FULL,
        S_COL,
        S_ROW,
        S_UPDATE
    } state_t;

    typedef enum logic [1:0] {
        M_FULL,
        M_RIGHT,
        M_LEFT,
        M_ROW
    } mode_t;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [PIX_W-1:0]  pix_t;

    state_t     state_q;
    mode_t      mode_q;
    mode_t      start_mode;
    addr_t      c_q;
    addr_t      l_q;
    addr_t      mem_addr_q;
    addr_t      next_addr;
    addr_t      first_addr;
    logic [3:0] idx_q;
    logic [3:0] last_idx;
    pix_t       tmp_q   [9];
    pix_t       win_q   [9];
    pix_t       win_d   [9];
    pix_t       new_pix [9];
    logic       mem_read_q;
    logic       valid_q;
    logic       busy_q;
    logic       done_q;

    logic unused_len;
    assign unused_len = ^length;

`ifdef SOBEL_WINLOAD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wcnt_q;
    logic          err_q;
    assign load_err = err_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT > 0);
    assign load_err   = 1'b0;
`endif

    // Address of the k-th pixel fetched for a move, centred on c, stride l.
    function automatic addr_t addr_of(
        input mode_t      m,
        input addr_t      c,
        input addr_t      l,
        input logic [3:0] k
    );
        logic [1:0] r;
        logic [1:0] cc;
        addr_t      base;
        addr_t      res;
        r  = 2'd0;
        cc = 2'd0;
        unique case (m)
            M_FULL: begin
                if (k < 4'd3) begin
                    r  = 2'd0;
                    cc = k[1:0];
                end else if (k < 4'd6) begin
                    r  = 2'd1;
                    cc = 2'(k - 4'd3);
                end else begin
                    r  = 2'd2;
                    cc = 2'(k - 4'd6);
                end
            end
            M_RIGHT: begin
                r  = k[1:0];
                cc = 2'd2;
            end
            M_LEFT: begin
                r  = k[1:0];
                cc = 2'd0;
            end
            default: begin
                r  = 2'd2;
                cc = k[1:0];
            end
        endcase
        unique case (r)
            2'd0:    base = c - l;
            2'd1:    base = c;
            default: base = c + l;
        endcase
        unique case (cc)
            2'd0:    res = base - addr_t'(1);
            2'd1:    res = base;
            default: res = base + addr_t'(1);
        endcase
        return res;
    endfunction

    // Decode the requested move; an invalid window forces a full reload.
    always_comb begin
        start_mode = M_FULL;
        if (direction != 2'b00 && valid_q) begin
            unique case (direction)
                2'b01:   start_mode = M_RIGHT;
                2'b10:   start_mode = M_LEFT;
                default: start_mode = M_ROW;
            endcase
        end
        first_addr = addr_of(start_mode, center_addr,
                             length[ADDR_W-1:0], 4'd0);
    end

    // Next fetch address and the window as it looks after this move.
    always_comb begin
        last_idx  = (mode_q == M_FULL) ? 4'd8 : 4'd2;
        next_addr = addr_of(mode_q, c_q, l_q, idx_q + 4'd1);
        for (int i = 0; i < 9; i++) begin
            new_pix[i] = (idx_q == 4'(i)) ? mem_rdata : tmp_q[i];
        end
        win_d = win_q;
        unique case (mode_q)
            M_FULL: win_d = new_pix;
            M_RIGHT: begin
                for (int r = 0; r < 3; r++) begin
                    win_d[3*r]   = win_q[3*r+1];
                    win_d[3*r+1] = win_q[3*r+2];
                    win_d[3*r+2] = new_pix[r];
                end
            end
            M_LEFT: begin
                for (int r = 0; r < 3; r++) begin
                    win_d[3*r+2] = win_q[3*r+1];
                    win_d[3*r+1] = win_q[3*r];
                    win_d[3*r]   = new_pix[r];
                end
            end
            default: begin
                for (int c = 0; c < 3; c++) begin
                    win_d[c]   = win_q[3+c];
                    win_d[3+c] = win_q[6+c];
                    win_d[6+c] = new_pix[c];
                end
            end
        endcase
    end

    // Fetch FSM: one outstanding read, window committed on the last pixel.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q    <= S_IDLE;
            mode_q     <= M_FULL;
            c_q        <= '0;
            l_q        <= '0;
            idx_q      <= '0;
            mem_addr_q <= '0;
            mem_read_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tmp_q      <= '{default: '0};
            win_q      <= '{default: '0};
`ifdef SOBEL_WINLOAD_TIMEOUT_EN
            wcnt_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_load) begin
                        c_q        <= center_addr;
                        l_q        <= length[ADDR_W-1:0];
                        idx_q      <= '0;
                        mode_q     <= start_mode;
                        mem_addr_q <= first_addr;
                        mem_read_q <= 1'b1;
                        busy_q     <= 1'b1;
`ifdef SOBEL_WINLOAD_TIMEOUT_EN
                        wcnt_q     <= '0;
                        err_q      <= 1'b0;
`endif
                        unique case (start_mode)
                            M_FULL: begin
                                state_q <= S_FULL;
                                valid_q <= 1'b0;
                            end
                            M_ROW:   state_q <= S_ROW;
                            default: state_q <= S_COL;
                        endcase
                    end
                end
                S_FULL, S_COL, S_ROW: begin
                    if (mem_rvalid) begin
                        tmp_q <= new_pix;
`ifdef SOBEL_WINLOAD_TIMEOUT_EN
                        wcnt_q <= '0;
`endif
                        if (idx_q == last_idx) begin
                            mem_read_q <= 1'b0;
                            win_q      <= win_d;
                            valid_q    <= 1'b1;
                            done_q     <= 1'b1;
                            state_q    <= S_UPDATE;
                        end else begin
                            idx_q      <= idx_q + 4'd1;
                            mem_addr_q <= next_addr;
                        end
                    end
`ifdef SOBEL_WINLOAD_TIMEOUT_EN
                    else if (wcnt_q == TW'(TIMEOUT - 1)) begin
                        wcnt_q     <= '0;
                        mem_read_q <= 1'b0;
                        valid_q    <= 1'b0;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + TW'(1);
                    end
`endif
                end
                S_UPDATE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < 9; k++) begin : g_win
        assign window[k*PIX_W +: PIX_W] = win_q[k];
    end

    assign mem_read     = mem_read_q;
    assign mem_addr     = mem_addr_q;
    assign window_valid = valid_q;
    assign busy         = busy_q;
    assign load_done    = done_q;

endmodule

// File: tb/tb_sobel_window_loader.sv
// tb_sobel_window_loader: randomized and directed checks of the window
// loader against a neighbourhood-of-centre reference model.
module tb_sobel_window_loader;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [11:0] length = 12'd8;
    logic        start_load = 1'b0;
    logic [1:0]  direction = 2'b00;
    logic [7:0]  center_addr = 8'd0;
    logic        mem_read;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rdata = 8'd0;
    logic        mem_rvalid = 1'b0;
    logic [71:0] window;
    logic        window_valid;
    logic        busy;
    logic        load_done;
    logic        load_err;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] mem [256];
    logic       stall = 1'b0;
    logic       rnd_lat = 1'b0;
    int         lat_cnt = 0;
    logic [7:0] rd_q [$];
    bit         ref_valid = 1'b0;

    sobel_window_loader dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .length       (length),
        .start_load   (start_load),
        .direction    (direction),
        .center_addr  (center_addr),
        .mem_read     (mem_read),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .window       (window),
        .window_valid (window_valid),
        .busy         (busy),
        .load_done    (load_done),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    // RAM responder: answers each request after 1..4 cycles, logs accepts.
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (!mem_read || mem_rvalid) begin
            mem_rvalid <= 1'b0;
            lat_cnt    <= rnd_lat ? int'($urandom_range(0, 3)) : 0;
        end else if (stall) begin
            mem_rvalid <= 1'b0;
        end else if (lat_cnt == 0) begin
            mem_rvalid <= 1'b1;
        end else begin
            lat_cnt    <= lat_cnt - 1;
            mem_rvalid <= 1'b0;
        end
        if (n_reset && mem_read && mem_rvalid) rd_q.push_back(mem_addr);
    end

    function automatic logic [7:0] nb(input int c, input int l, input int k);
        int a;
        a = c + (k / 3 - 1) * l + (k % 3 - 1);
        return 8'(a & 255);
    endfunction

    function automatic logic [71:0] nb_win(input int c, input int l);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = mem[nb(c, l, k)];
        return w;
    endfunction

    task automatic fill_ident();
        for (int a = 0; a < 256; a++) mem[a] = 8'(a);
    endtask

    task automatic fill_rand();
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    endtask

    task automatic do_reset();
        n_reset    = 1'b0;
        start_load = 1'b0;
        repeat (2) @(negedge clk);
        n_reset   = 1'b1;
        ref_valid = 1'b0;
    endtask

    // Issue one move at the current negedge and check the whole transaction.
    task automatic do_load(input logic [1:0] dir, input int ctr,
                           input bit chk_lat, input bit mid_pulse);
        int          l;
        bit          full;
        logic [7:0]  exp_a [$];
        logic [71:0] prev_w;
        logic [71:0] exp_w;
        int          cyc;
        bit          done;
        bit          moved;
        bit          ok;
        int          exp_lat;
        l    = int'(length) & 255;
        full = (dir == 2'b00) || !ref_valid;
        if (full) begin
            for (int k = 0; k < 9; k++) exp_a.push_back(nb(ctr, l, k));
        end else begin
            for (int r = 0; r < 3; r++) begin
                case (dir)
                    2'b01:   exp_a.push_back(nb(ctr, l, 3 * r + 2));
                    2'b10:   exp_a.push_back(nb(ctr, l, 3 * r));
                    default: exp_a.push_back(nb(ctr, l, 6 + r));
                endcase
            end
        end
        exp_w   = nb_win(ctr, l);
        exp_lat = full ? 19 : 7;
        prev_w  = window;
        rd_q.delete();
        start_load  = 1'b1;
        direction   = dir;
        center_addr = 8'(ctr);
        cyc   = 0;
        done  = 1'b0;
        moved = 1'b0;
        while (cyc < 300 && !done) begin
            @(negedge clk);
            start_load = 1'b0;
            cyc++;
            if (mid_pulse && cyc == 4) begin
                start_load  = 1'b1;
                direction   = 2'b00;
                center_addr = 8'd100;
            end
            if (cyc == 1) begin
                n_checks++;
                if (window_valid !== (full ? 1'b0 : 1'b1) || busy !== 1'b1
                    || load_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_flags valid=%b busy=%b err=%b full=%0d",
                             window_valid, busy, load_err, full);
                end
            end
            if (load_done === 1'b1) done = 1'b1;
            else if (window !== prev_w) moved = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL load_done_timeout got none required pulse");
        end
        if (chk_lat) begin
            n_checks++;
            if (cyc != exp_lat) begin
                n_fail++;
                $display("FAIL latency got %0d required %0d", cyc, exp_lat);
            end
        end
        ok = (rd_q.size() == exp_a.size());
        if (ok) for (int i = 0; i < exp_a.size(); i++) ok &= (rd_q[i] == exp_a[i]);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL read_addrs got %p required %p", rd_q, exp_a);
        end
        n_checks++;
        if (window !== exp_w || window_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL window got %h/%b required %h/1", window,
                     window_valid, exp_w);
        end
        n_checks++;
        if (moved) begin
            n_fail++;
            $display("FAIL window_stable changed during fetch required stable");
        end
        ref_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (load_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done load_done=%b busy=%b required 0/0",
                     load_done, busy);
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (mem_read !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0
            || window_valid !== 1'b0 || load_err !== 1'b0 || window !== '0) begin
            n_fail++;
            $display("FAIL reset_state rd=%b busy=%b done=%b v=%b err=%b w=%h",
                     mem_read, busy, load_done, window_valid, load_err, window);
        end
        n_reset   = 1'b1;
        ref_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_load();
        length = 12'd8;
        fill_ident();
        do_load(2'b00, 9, 1'b1, 1'b0);
        n_checks++;
        if (window !== {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8,
                        8'd2, 8'd1, 8'd0}) begin
            n_fail++;
            $display("FAIL full_window got %h", window);
        end
    endtask

    task automatic test_right_left();
        do_load(2'b01, 10, 1'b1, 1'b0);
        n_checks++;
        if (window !== {8'd19, 8'd18, 8'd17, 8'd11, 8'd10, 8'd9,
                        8'd3, 8'd2, 8'd1}) begin
            n_fail++;
            $display("FAIL right_window got %h", window);
        end
        do_load(2'b10, 9, 1'b1, 1'b0);
        n_checks++;
        if (window !== {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8,
                        8'd2, 8'd1, 8'd0}) begin
            n_fail++;
            $display("FAIL left_window got %h", window);
        end
    endtask

    task automatic test_next_row();
        do_load(2'b11, 17, 1'b1, 1'b0);
        n_checks++;
        if (window !== {8'd26, 8'd25, 8'd24, 8'd18, 8'd17, 8'd16,
                        8'd10, 8'd9, 8'd8}) begin
            n_fail++;
            $display("FAIL row_window got %h", window);
        end
    endtask

    task automatic test_wrap_guard();
        logic [7:0] ew [9];
        bit         ok;
        ew = '{8'd247, 8'd248, 8'd249, 8'd255, 8'd0, 8'd1, 8'd7, 8'd8, 8'd9};
        do_reset();
        length = 12'd8;
        do_load(2'b01, 0, 1'b1, 1'b1);
        ok = (rd_q.size() == 9);
        if (ok) for (int i = 0; i < 9; i++) ok &= (rd_q[i] == ew[i]);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wrap_addrs got %p", rd_q);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        length = 12'd8;
        rd_q.delete();
        start_load  = 1'b1;
        direction   = 2'b00;
        center_addr = 8'd50;
        cyc = 0;
        while (cyc < 100 && rd_q.size() < 4) begin
            @(negedge clk);
            start_load = 1'b0;
            cyc++;
        end
        n_checks++;
        if (rd_q.size() != 4) begin
            n_fail++;
            $display("FAIL mid_reads got %0d required 4", rd_q.size());
        end
        n_reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_read !== 1'b0 || busy !== 1'b0 || window !== '0
            || window_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset rd=%b busy=%b v=%b w=%h required zeros",
                     mem_read, busy, window_valid, window);
        end
        n_reset   = 1'b1;
        ref_valid = 1'b0;
        @(negedge clk);
        do_load(2'b10, 77, 1'b1, 1'b0);
    endtask

    task automatic test_stall();
        int  cyc;
        bit  bad;
        bit  saw_done;
        fill_rand();
        length = 12'd8;
        stall  = 1'b1;
        start_load  = 1'b1;
        direction   = 2'b00;
        center_addr = 8'd5;
        bad      = 1'b0;
        saw_done = 1'b0;
`ifdef SOBEL_WINLOAD_TIMEOUT_EN
        for (cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            start_load = 1'b0;
            if (load_done === 1'b1) saw_done = 1'b1;
            if (cyc == 15) begin
                n_checks++;
                if (busy !== 1'b1 || load_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tmo_early busy=%b err=%b required 1/0",
                             busy, load_err);
                end
            end
        end
        n_checks++;
        if (load_err !== 1'b1 || busy !== 1'b0 || mem_read !== 1'b0
            || window_valid !== 1'b0 || saw_done) begin
            n_fail++;
            $display("FAIL tmo_abort err=%b busy=%b rd=%b v=%b done=%b",
                     load_err, busy, mem_read, window_valid, saw_done);
        end
        stall = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (load_err !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_sticky err=%b required 1", load_err);
        end
        ref_valid = 1'b0;
        do_load(2'b01, 40, 1'b1, 1'b0);
`else
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start_load = 1'b0;
            if (load_done === 1'b1 || load_err !== 1'b0 || mem_read !== 1'b1
                || busy !== 1'b1 || mem_addr !== nb(5, 8, 0)) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL stall_hold rd=%b a=%0d err=%b required 1/%0d/0",
                     mem_read, mem_addr, load_err, nb(5, 8, 0));
        end
        stall = 1'b0;
        cyc = 0;
        while (cyc < 100 && load_done !== 1'b1) begin
            @(negedge clk);
            cyc++;
        end
        if (load_done === 1'b1) saw_done = 1'b1;
        n_checks++;
        if (!saw_done || window !== nb_win(5, 8)) begin
            n_fail++;
            $display("FAIL stall_done done=%b w=%h required %h", saw_done,
                     window, nb_win(5, 8));
        end
        ref_valid = 1'b1;
        @(negedge clk);
`endif
    endtask

    task automatic test_random_walk();
        int c;
        int l;
        int m;
        for (int s = 0; s < 4; s++) begin
            rnd_lat = s[0];
            length  = 12'($urandom_range(1, 4095));
            l       = int'(length) & 255;
            fill_rand();
            c = int'($urandom_range(0, 255));
            do_load(2'b00, c, !rnd_lat, 1'b0);
            for (int j = 0; j < 12; j++) begin
                m = int'($urandom_range(1, 3));
                case (m)
                    1:       c = (c + 1) & 255;
                    2:       c = (c - 1) & 255;
                    default: c = (c + l) & 255;
                endcase
                do_load(2'(m), c, !rnd_lat, 1'b0);
            end
        end
        rnd_lat = 1'b0;
    endtask

    initial begin
        fill_ident();
        @(negedge clk);
        test_reset();
        test_full_load();
        test_right_left();
        test_next_row();
        test_wrap_guard();
        test_reset_mid();
        test_stall();
        test_random_walk();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_window_loader.md
Name: sobel_window_loader

Overview:
Responder to the serpentine address/move sequencer. It fetches pixels from the image RAM and holds the 3x3 neighbourhood window consumed by the Sobel kernel.
- On each move command it fetches only the new column or row.
- It shifts the window and pulses load_done.
- A full 9-pixel load is done on the first window.

Parameters:
ADDR_W, 8, width of pixel RAM address and of center_addr
PIX_W, 8, pixel width
LEN_W, 12, width of image row length input
TIMEOUT, 15, max wait cycles for mem_rvalid (optional feature only)

Ports:
clk  in  1  clock, rising edge
n_reset  in  1  reset, synchronous, active-low
length  in  LEN_W  image row length in pixels; low ADDR_W bits used as row stride
start_load  in  1  one-cycle request; samples direction and center_addr
direction  in  2  00 full load, 01 right, 10 left, 11 next row (adds length)
center_addr  in  ADDR_W  RAM address of window center after the move
mem_read  out  1  read request, held until accepted
mem_addr  out  ADDR_W  read address, valid while mem_read=1
mem_rdata  in  PIX_W  read data, valid when mem_rvalid=1
mem_rvalid  in  1  read data valid / request accepted
window  out  9*PIX_W  w[r][c] packed at index (3r+c)*PIX_W; r0 top row, c0 left column
window_valid  out  1  window holds a complete neighbourhood
busy  out  1  fetch in progress
load_done  out  1  one-cycle pulse when window updated
load_err  out  1  timeout flag (optional feature; tied 0 otherwise)

Behaviour:
- Reset (synchronous, active-low, n_reset=0 at rising clk): state IDLE; all outputs 0; window all 0; temp regs and counters 0. Applies mid-fetch: the fetch is aborted and the window is cleared.
- States: IDLE, FULL, COL, ROW, UPDATE.
- IDLE + start_load=1: latch center_addr (C) and length stride L (mod 2^ADDR_W).
  - direction=00, or window_valid=0 with any direction -> FULL. window_valid cleared immediately.
  - direction 01 or 10 -> COL.
  - direction 11 -> ROW.
- start_load while busy=1: ignored, no effect.
- Read protocol: one outstanding read at a time.
  - mem_read=1 with mem_addr stable until the cycle mem_rvalid=1; the pixel is captured in that cycle.
  - The next address is presented the following cycle.
  - mem_rvalid while mem_read=0 is ignored.
  - Minimum 2 cycles per pixel (mem_rvalid earliest 1 cycle after request).
- Address math: all modulo 2^ADDR_W (wraps).
  - FULL order, row-major: C-L-1, C-L, C-L+1, C-1, C, C+1, C+L-1, C+L, C+L+1.
  - COL right: C+1-L, C+1, C+1+L.
  - COL left: C-1-L, C-1, C-1+L.
  - ROW: C+L-1, C+L, C+L+1.
- Captured pixels go to temp registers; window outputs stay stable during the whole fetch.
- UPDATE (1 cycle) applies the change atomically:
  - FULL: w <= 9 temps.
  - Right: w[r][0]<=w[r][1], w[r][1]<=w[r][2], w[r][2]<=new[r].
  - Left: w[r][2]<=w[r][1], w[r][1]<=w[r][0], w[r][0]<=new[r].
  - Row: w[0]<=w[1], w[1]<=w[2], w[2][c]<=new[c].
- Same cycle as UPDATE: load_done=1, window_valid=1, then return to IDLE; busy drops the next cycle.
- busy=1 in FULL, COL, ROW, UPDATE.
- Latency with 1-cycle RAM: start_load at cycle T -> load_done at T+7 (3 pixels) or T+19 (9 pixels).
- A new start_load is accepted in the cycle after load_done.

Optional Feature:
SOBEL_WINLOAD_TIMEOUT_EN
- Defined:
  - A per-read wait counter counts cycles with mem_read=1 and mem_rvalid=0.
  - On reaching TIMEOUT: abort, drop mem_read, set window_valid=0, set load_err=1 (sticky until the next accepted start_load or reset), return to IDLE. No load_done.
- Undefined: no counter; waits indefinitely; load_err constant 0.

Test Plan:
- Full load: length=8, mem[a]=a, RAM rvalid 1 cycle after request; start_load dir=00, center=9 -> reads 0,1,2,8,9,10,16,17,18 in order; load_done at T+19; window rows {0,1,2},{8,9,10},{16,17,18}; window_valid=1.
- Right then left: after the full load, dir=01 center=10 -> reads 3,11,19; window {1,2,3},{9,10,11},{17,18,19}. Then dir=10 center=9 -> reads 0,8,16; window back to {0,1,2},{8,9,10},{16,17,18}.
- Next row: then dir=11 center=17 -> reads 24,25,26; window {8,9,10},{16,17,18},{24,25,26}; load_done latency 7.
- Wrap and guard: from reset, dir=01 center=0 -> treated as full load; reads 247,248,249,255,0,1,7,8,9. A second start_load mid-fetch is ignored (read count stays 9).
- Reset mid-op: n_reset=0 after the 4th read of a full load -> next cycle mem_read=0, busy=0, window=0, window_valid=0. Afterwards a fresh load is correct.
- With SOBEL_WINLOAD_TIMEOUT_EN, TIMEOUT=15: mem_rvalid held 0 -> load_err=1 after 15 wait cycles; busy=0, window_valid=0, no load_done. The next start_load clears load_err.
